// File: rtl/apu_pkg.sv
// Shared widths, mix scaling and FSM state encoding for the APU voice mixer.
package apu_pkg;

  localparam int APU_SAMPLE_W        = 16;
  localparam int APU_VOL_W           = 8;
  localparam int APU_MIX_UNITY_SHIFT = 7;
  // signed sample x {1'b0, vol}
  localparam int APU_PROD_W          = APU_SAMPLE_W + APU_VOL_W + 1;

  localparam logic [1:0] APU_ST_IDLE = 2'd0;
  localparam logic [1:0] APU_ST_MAC  = 2'd1;
  localparam logic [1:0] APU_ST_SAT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = APU_ST_IDLE,
    MAC  = APU_ST_MAC,
    SAT  = APU_ST_SAT
  } apu_state_e;

endpackage

// File: rtl/apu_mix_sat.sv
// Scales one channel accumulator down by unity gain (floor) and clamps it to a
// signed 16-bit sample, flagging when the clamp was needed.
module apu_mix_sat
  import apu_pkg::*;
#(
  parameter int ACC_W = 27
) (
  input  logic [ACC_W-1:0]        acc,
  output logic [APU_SAMPLE_W-1:0] sat,
  output logic                    clip
);

  localparam int SH_W = ACC_W - APU_MIX_UNITY_SHIFT;

  logic [SH_W-1:0]              shifted;
  logic [SH_W-APU_SAMPLE_W:0]   top_bits;

  // Dropping the low bits of a two's complement value is a floor division.
  assign shifted  = acc[ACC_W-1:APU_MIX_UNITY_SHIFT];
  // The value fits in 16 bits only if every bit from the sign down to bit 15 agrees.
  assign top_bits = shifted[SH_W-1:APU_SAMPLE_W-1];
  assign clip     = !((&top_bits) || !(|top_bits));

  always_comb begin
    sat = shifted[APU_SAMPLE_W-1:0];
    if (clip) begin
      if (shifted[SH_W-1]) begin
        sat = {1'b1, {(APU_SAMPLE_W-1){1'b0}}};
      end else begin
        sat = {1'b0, {(APU_SAMPLE_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/apu_mixer.sv
// Time-multiplexed stereo voice mixer: snapshots all voices, MACs one voice per
// cycle, saturates and hands a packed L/R word to the audio-out FIFO.
module apu_mixer
  import apu_pkg::*;
#(
  parameter int NVOICE = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NVOICE*APU_SAMPLE_W-1:0] voice_sample,
  input  logic [NVOICE*APU_VOL_W-1:0]    voice_vol_l,
  input  logic [NVOICE*APU_VOL_W-1:0]    voice_vol_r,
  output logic                           voice_adv,
  output logic [31:0]                    out_sample,
  output logic                           out_valid,
  input  logic                           out_rdy,
  output logic [1:0]                     clip,
  input  logic                           clip_clr
);

  localparam int ACC_W = APU_PROD_W + $clog2(NVOICE);
  localparam int IDX_W = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVOICE - 1);

  logic signed [APU_SAMPLE_W-1:0] samp_in  [NVOICE];
  logic        [APU_VOL_W-1:0]    vol_l_in [NVOICE];
  logic        [APU_VOL_W-1:0]    vol_r_in [NVOICE];

  logic signed [APU_SAMPLE_W-1:0] samp_reg  [NVOICE];
  logic        [APU_VOL_W-1:0]    vol_l_reg [NVOICE];
  logic        [APU_VOL_W-1:0]    vol_r_reg [NVOICE];

  apu_state_e              state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic signed [ACC_W-1:0] acc_l_reg, acc_l_next;
  logic signed [ACC_W-1:0] acc_r_reg, acc_r_next;
  logic [31:0]             out_sample_reg, out_sample_next;
  logic                    out_valid_reg, out_valid_next;
  logic [1:0]              clip_reg, clip_next;
  logic                    snap_en;
  logic                    adv_comb;

  logic signed [APU_PROD_W-1:0]   prod_l, prod_r;
  logic        [APU_SAMPLE_W-1:0] sat_l, sat_r;
  logic                           clip_l, clip_r;

  genvar gi;
  generate
    for (gi = 0; gi < NVOICE; gi++) begin : g_unpack
      assign samp_in[gi]  = voice_sample[gi*APU_SAMPLE_W +: APU_SAMPLE_W];
      assign vol_l_in[gi] = voice_vol_l[gi*APU_VOL_W +: APU_VOL_W];
      assign vol_r_in[gi] = voice_vol_r[gi*APU_VOL_W +: APU_VOL_W];
    end
  endgenerate

  // Volumes are unsigned, so a zero sign bit is prepended before the signed multiply.
  assign prod_l = samp_reg[idx_reg] * $signed({1'b0, vol_l_reg[idx_reg]});
  assign prod_r = samp_reg[idx_reg] * $signed({1'b0, vol_r_reg[idx_reg]});

  apu_mix_sat #(.ACC_W(ACC_W)) u_sat_l (
    .acc  (acc_l_reg),
    .sat  (sat_l),
    .clip (clip_l)
  );

  apu_mix_sat #(.ACC_W(ACC_W)) u_sat_r (
    .acc  (acc_r_reg),
    .sat  (sat_r),
    .clip (clip_r)
  );

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    acc_l_next      = acc_l_reg;
    acc_r_next      = acc_r_reg;
    out_sample_next = out_sample_reg;
    out_valid_next  = out_valid_reg && !out_rdy;
    clip_next       = clip_clr ? 2'b00 : clip_reg;
    snap_en         = 1'b0;
    adv_comb        = 1'b0;

    if (!en) begin
      state_next     = IDLE;
      idx_next       = '0;
      acc_l_next     = '0;
      acc_r_next     = '0;
      out_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          adv_comb   = 1'b1;
          snap_en    = 1'b1;
          idx_next   = '0;
          acc_l_next = '0;
          acc_r_next = '0;
          state_next = MAC;
        end
        MAC: begin
          acc_l_next = acc_l_reg + ACC_W'(prod_l);
          acc_r_next = acc_r_reg + ACC_W'(prod_r);
          if (idx_reg == IDX_LAST) begin
            state_next = SAT;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
        SAT: begin
          // A word being accepted this cycle frees the slot, so back-to-back frames never gap.
          if (!out_valid_reg || out_rdy) begin
            out_sample_next = {sat_l, sat_r};
            out_valid_next  = 1'b1;
            clip_next       = clip_next | {clip_l, clip_r};
            state_next      = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      acc_l_reg      <= '0;
      acc_r_reg      <= '0;
      out_sample_reg <= '0;
      out_valid_reg  <= 1'b0;
      clip_reg       <= 2'b00;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      acc_l_reg      <= acc_l_next;
      acc_r_reg      <= acc_r_next;
      out_sample_reg <= out_sample_next;
      out_valid_reg  <= out_valid_next;
      clip_reg       <= clip_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NVOICE; i++) begin
        samp_reg[i]  <= '0;
        vol_l_reg[i] <= '0;
        vol_r_reg[i] <= '0;
      end
    end else if (snap_en) begin
      for (int i = 0; i < NVOICE; i++) begin
        samp_reg[i]  <= samp_in[i];
        vol_l_reg[i] <= vol_l_in[i];
        vol_r_reg[i] <= vol_r_in[i];
      end
    end
  end

  // Gated by rst_n so the strobe drops the instant reset asserts.
  assign voice_adv  = adv_comb && rst_n;
  assign out_sample = out_sample_reg;
  assign out_valid  = out_valid_reg;
  assign clip       = clip_reg;

endmodule

// File: doc/apu_mixer.md
Name: apu_mixer

Overview:
- Time-multiplexed stereo voice mixer. Sits directly upstream of the audio-out path and feeds the sample FIFO that supplies apu_aout.
- Each frame snapshots NVOICE signed 16-bit voice samples and per-voice left/right volumes, then multiply-accumulates one voice per cycle.
- Saturates each channel to 16 bits and presents a packed 32-bit stereo word on a valid/ready handshake.
- Frame rate is set entirely by downstream backpressure.

Parameters:
- NVOICE, 4, number of voices; legal range 1..16.
- ACC_W, 25+$clog2(NVOICE), accumulator width. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  mixer enable. Low aborts any frame and holds the block idle.
- voice_sample  in  NVOICE*16  signed samples; voice i is in bits [16i+15:16i].
- voice_vol_l  in  NVOICE*8  unsigned left gain per voice; 128 = unity.
- voice_vol_r  in  NVOICE*8  unsigned right gain per voice; 128 = unity.
- voice_adv  out  1  one-cycle pulse; voice inputs are sampled on this cycle's clock edge, and upstream voices advance.
- out_sample  out  32  [31:16] left, [15:0] right, both signed.
- out_valid  out  1  out_sample holds a valid word.
- out_rdy  in  1  consumer accepts the word when out_valid && out_rdy.
- clip  out  2  sticky saturation flags: [1] left, [0] right.
- clip_clr  in  1  clears both clip flags.

Behaviour:
- Reset values: out_sample=0, out_valid=0, voice_adv=0, clip=0, state=IDLE, accumulators=0, voice index=0.
- States:
  - IDLE: if en, assert voice_adv, snapshot all voice_* inputs, clear both accumulators, set index=0, go to MAC.
  - MAC: for one cycle per voice, acc_l += s[idx]*vol_l[idx] and acc_r += s[idx]*vol_r[idx].
    - Products are signed 16 x signed {1'b0,vol} = 25 bits, sign-extended to ACC_W.
    - After the idx=NVOICE-1 cycle, go to SAT.
  - SAT: arithmetic shift of each accumulator right by 7 (truncation toward -inf), then saturate to [-32768, 32767].
    - Commit when !out_valid || out_rdy: load out_sample, set out_valid, go to IDLE.
    - Otherwise stall in SAT with accumulators held.
- Timing: with voice_adv high in cycle T and no stall, out_valid is first high in cycle T+NVOICE+2. Minimum frame period is NVOICE+2 cycles.
- Output register:
  - out_valid falls on the edge after out_valid && out_rdy, unless SAT commits in that same cycle. In that case the new word loads and out_valid stays high.
  - out_sample is stable while out_valid && !out_rdy.
- Clip flags:
  - clip[1]/clip[0] set on a SAT commit whose left/right value saturated.
  - clip_clr clears them. If clip_clr and a new saturation occur in the same cycle, set wins.
- en low:
  - Next edge: state goes to IDLE, accumulators and index clear, out_valid clears, voice_adv stays 0.
  - clip flags hold their value.
  - A frame aborted mid-MAC never produces output. The voices it already advanced are lost; this is accepted.
- Volume 0 mutes a voice. Volume 255 gives gain of about 1.99.
- NVOICE=1 still passes through MAC for one cycle.
- Reset mid-frame returns the block to the reset values immediately (asynchronous).

Decomposition:
- Shared package apu_pkg:
  - APU_SAMPLE_W=16
  - APU_VOL_W=8
  - APU_MIX_UNITY_SHIFT=7
  - state encoding localparams: IDLE, MAC, SAT
- One natural sub-module: apu_mix_sat. Purely combinational; takes an ACC_W signed value and produces {shifted, saturated 16-bit value, clip bit}. Instantiated twice, once for left and once for right.
- The MAC datapath and FSM stay in apu_mixer.

Test Plan:
- Unity passthrough:
  - Stimulus: NVOICE=4, voice0=0x4000, vol_l0=vol_r0=128, other vols 0, out_rdy=1.
  - Required: out_sample=0x40004000, out_valid first high 6 cycles after voice_adv, clip=0.
- Positive saturation:
  - Stimulus: voice0=voice1=0x7000, all vol_l=128, vol_r=64.
  - Required: left=0x7FFF with clip[1]=1; right=0x7000 with clip[0]=0.
- Negative rounding and saturation:
  - Stimulus: voice0=0xFFFF with vol 64, giving left=0xFFFF (-1, floor). Then voice0=0x8000 with vol 255.
  - Required: left=0x8000 and clip[1] set; clip_clr then clears it.
- Backpressure:
  - Stimulus: hold out_rdy=0 for 40 cycles.
  - Required: exactly one further voice_adv, FSM parked in SAT, out_sample stable.
  - Then out_rdy=1 for one cycle: the new word loads with no gap in out_valid and voice_adv follows next cycle.
- Enable abort:
  - Stimulus: drop en during the second MAC cycle.
  - Required: no out_valid, voice_adv silent while en=0, clip unchanged.
  - After re-enable, the first output equals a fresh-snapshot mix.
- Async reset:
  - Stimulus: assert rst_n low while in SAT with out_valid=1.
  - Required: all outputs 0 immediately, with no clock edge needed.
